// File: rtl/layer_seq.sv
// rtl/layer_seq.sv - per-image CNN layer sequencer with watchdog and cycle counter
//
// Started once per image. Pulses each layer engine's start in index order,
// waits for that layer's done, then reports completion to the image loop.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   inner_start  in   1-cycle pulse: run all layers for one image
//   layer_done   in   [NUM_LAYERS] 1-cycle done pulse per layer engine
//   layer_start  out  [NUM_LAYERS] one-hot 1-cycle start pulse per layer
//   cur_layer    out  [LBW] active layer index (memory bank select)
//   busy         out  high from launch until inner_done or error
//   inner_done   out  1-cycle pulse: all layers completed
//   err          out  sticky watchdog error flag
//   err_layer    out  [LBW] layer index that timed out
//   perf_cycles  out  [CYC_BW] cycles of last completed image, saturating
module layer_seq #(
  parameter int NUM_LAYERS = 5,
  parameter int TIMEOUT    = 65535,
  parameter int CYC_BW     = 24,
  parameter int LBW        = $clog2(NUM_LAYERS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inner_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic [LBW-1:0]        cur_layer,
  output logic                  busy,
  output logic                  inner_done,
  output logic                  err,
  output logic [LBW-1:0]        err_layer,
  output logic [CYC_BW-1:0]     perf_cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam logic [CYC_BW-1:0] CYC_MAX = {CYC_BW{1'b1}};
  localparam bit                WD_EN   = (TIMEOUT != 0);
  localparam logic [31:0]       WD_LAST = WD_EN ? 32'(TIMEOUT - 1) : 32'd0;

  state_t                  state, state_n;
  logic [NUM_LAYERS-1:0]   layer_start_n;
  logic [LBW-1:0]          cur_layer_n, err_layer_n;
  logic                    busy_n, inner_done_n, err_n;
  logic [CYC_BW-1:0]       perf_n, cnt, cnt_n, cnt_inc;
  logic [31:0]             wd, wd_n;
  logic                    done_hit, last_layer, timeout_hit;

  // Only the active layer's done bit matters; all other bits are ignored.
  assign done_hit    = |(layer_done & (NUM_LAYERS'(1) << cur_layer));
  assign last_layer  = (cur_layer == LBW'(NUM_LAYERS - 1));
  assign timeout_hit = WD_EN && (wd == WD_LAST);
  assign cnt_inc     = (cnt == CYC_MAX) ? cnt : cnt + CYC_BW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      layer_start <= '0;
      cur_layer   <= '0;
      busy        <= 1'b0;
      inner_done  <= 1'b0;
      err         <= 1'b0;
      err_layer   <= '0;
      perf_cycles <= '0;
      cnt         <= '0;
      wd          <= '0;
    end else begin
      state       <= state_n;
      layer_start <= layer_start_n;
      cur_layer   <= cur_layer_n;
      busy        <= busy_n;
      inner_done  <= inner_done_n;
      err         <= err_n;
      err_layer   <= err_layer_n;
      perf_cycles <= perf_n;
      cnt         <= cnt_n;
      wd          <= wd_n;
    end
  end

  always_comb begin
    state_n       = state;
    layer_start_n = '0;
    cur_layer_n   = cur_layer;
    busy_n        = busy;
    inner_done_n  = 1'b0;
    err_n         = err;
    err_layer_n   = err_layer;
    perf_n        = perf_cycles;
    cnt_n         = cnt;
    wd_n          = wd;
    case (state)
      S_IDLE, S_ERR: begin
        // A launch from ERR also clears the sticky error.
        if (inner_start) begin
          state_n       = S_WAIT;
          layer_start_n = NUM_LAYERS'(1);
          cur_layer_n   = '0;
          busy_n        = 1'b1;
          err_n         = 1'b0;
          err_layer_n   = '0;
          cnt_n         = '0;
          wd_n          = '0;
        end
      end
      S_WAIT: begin
        cnt_n = cnt_inc;
        // Done takes priority over a timeout in the same cycle.
        if (done_hit) begin
          wd_n = '0;
          if (last_layer) begin
            state_n      = S_IDLE;
            inner_done_n = 1'b1;
            busy_n       = 1'b0;
            perf_n       = cnt_inc;
          end else begin
            cur_layer_n   = cur_layer + LBW'(1);
            layer_start_n = NUM_LAYERS'(1) << cur_layer_n;
          end
        end else if (timeout_hit) begin
          state_n     = S_ERR;
          err_n       = 1'b1;
          err_layer_n = cur_layer;
          busy_n      = 1'b0;
        end else if (WD_EN) begin
          wd_n = wd + 32'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_layer_seq.sv
// tb/tb_layer_seq.sv - directed self-checking bench for layer_seq
module tb_layer_seq;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         inner_start = 1'b0;
  logic [N-1:0] layer_done = '0;

  logic [N-1:0] a_ls, t_ls, s_ls;
  logic [2:0]   a_cl, t_cl, s_cl, a_el, t_el, s_el;
  logic         a_busy, t_busy, s_busy, a_idn, t_idn, s_idn, a_err, t_err, s_err;
  logic [23:0]  a_perf, t_perf;
  logic [3:0]   s_perf;

  int ncmp = 0;
  int nerr = 0;
  int st[5];
  int dn[5];

  always #5 clk = ~clk;

  layer_seq d_a (
    .clk(clk), .reset(reset), .inner_start(inner_start), .layer_done(layer_done),
    .layer_start(a_ls), .cur_layer(a_cl), .busy(a_busy), .inner_done(a_idn),
    .err(a_err), .err_layer(a_el), .perf_cycles(a_perf)
  );

  layer_seq #(.TIMEOUT(8)) d_t (
    .clk(clk), .reset(reset), .inner_start(inner_start), .layer_done(layer_done),
    .layer_start(t_ls), .cur_layer(t_cl), .busy(t_busy), .inner_done(t_idn),
    .err(t_err), .err_layer(t_el), .perf_cycles(t_perf)
  );

  layer_seq #(.CYC_BW(4)) d_s (
    .clk(clk), .reset(reset), .inner_start(inner_start), .layer_done(layer_done),
    .layer_start(s_ls), .cur_layer(s_cl), .busy(s_busy), .inner_done(s_idn),
    .err(s_err), .err_layer(s_el), .perf_cycles(s_perf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    inner_start = 1'b0;
    layer_done  = '0;
    reset       = 1'b1;
    tick();
    reset       = 1'b0;
  endtask

  // Drives one image (launch at cycle 0, dones from dn[]) plus optional
  // spurious inputs, and checks d_a every cycle against st[]/dn[].
  task automatic run_img(input int spur_c, input logic [N-1:0] spur_b,
                         input int rs_c, input int len);
    logic [N-1:0] els;
    logic [2:0]   ecl;
    int           n;
    for (int c = 0; c < len; c++) begin
      inner_start = (c == 0) || (c == rs_c);
      layer_done  = '0;
      for (int k = 0; k < N; k++) if (dn[k] == c) layer_done[k] = 1'b1;
      if (c == spur_c) layer_done = layer_done | spur_b;
      tick();
      n   = c + 1;
      els = '0;
      ecl = 3'd0;
      for (int k = 0; k < N; k++) begin
        if (st[k] == n) els[k] = 1'b1;
        if (n >= st[k]) ecl = 3'(k);
      end
      chk($sformatf("layer_start@%0d", n), 32'(a_ls), 32'(els));
      chk($sformatf("cur_layer@%0d", n), 32'(a_cl), 32'(ecl));
      chk($sformatf("busy@%0d", n), 32'(a_busy), 32'(n >= st[0] && n <= dn[4]));
      chk($sformatf("inner_done@%0d", n), 32'(a_idn), 32'(n == dn[4] + 1));
      chk($sformatf("err@%0d", n), 32'(a_err), 32'd0);
    end
    inner_start = 1'b0;
    layer_done  = '0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("rst_layer_start", 32'(a_ls), 32'd0);
    chk("rst_cur_layer", 32'(a_cl), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_inner_done", 32'(a_idn), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_err_layer", 32'(a_el), 32'd0);
    chk("rst_perf", 32'(a_perf), 32'd0);
    chk("rst_t_err", 32'(t_err), 32'd0);
    reset = 1'b0;

    // T1 nominal and T6 saturation (same stimulus, CYC_BW=4 instance)
    st = '{1, 11, 21, 31, 41};
    dn = '{10, 20, 30, 40, 50};
    run_img(-1, '0, -1, 53);
    chk("t1_perf", 32'(a_perf), 32'd50);
    chk("t6_perf_sat", 32'(s_perf), 32'd15);
    chk("t6_inner_done_seen_busy", 32'(s_busy), 32'd0);

    // T2 back-to-back
    pulse_reset();
    st = '{1, 2, 3, 4, 5};
    dn = '{1, 2, 3, 4, 5};
    run_img(-1, '0, -1, 8);
    chk("t2_perf", 32'(a_perf), 32'd5);

    // T4 spurious done[3] during layer 1 and inner_start while busy
    pulse_reset();
    st = '{1, 11, 21, 31, 41};
    dn = '{10, 20, 30, 40, 50};
    run_img(15, 5'b01000, 5, 53);
    chk("t4_perf", 32'(a_perf), 32'd50);

    // T3 timeout on TIMEOUT=8 instance; layer 1 done lands on the last
    // watchdog cycle (done wins), layer 2 never completes.
    pulse_reset();
    inner_start = 1'b1;
    tick();                                 // cycle 1
    inner_start = 1'b0;
    chk("t3_ls0", 32'(t_ls), 32'd1);
    layer_done = 5'b00001;
    tick();                                 // cycle 2
    layer_done = '0;
    chk("t3_ls1", 32'(t_ls), 32'd2);
    chk("t3_cl1", 32'(t_cl), 32'd1);
    for (int i = 0; i < 7; i++) tick();     // cycle 9
    layer_done = 5'b00010;
    tick();                                 // cycle 10
    layer_done = '0;
    chk("t3_done_wins_ls2", 32'(t_ls), 32'd4);
    chk("t3_done_wins_err", 32'(t_err), 32'd0);
    chk("t3_cl2", 32'(t_cl), 32'd2);
    for (int i = 0; i < 7; i++) tick();     // cycle 17
    chk("t3_pre_err", 32'(t_err), 32'd0);
    chk("t3_pre_busy", 32'(t_busy), 32'd1);
    tick();                                 // cycle 18
    chk("t3_err", 32'(t_err), 32'd1);
    chk("t3_err_layer", 32'(t_el), 32'd2);
    chk("t3_busy", 32'(t_busy), 32'd0);
    chk("t3_no_inner_done", 32'(t_idn), 32'd0);
    layer_done = 5'b00100;
    tick();
    layer_done = '0;
    tick();
    chk("t3_err_sticky", 32'(t_err), 32'd1);
    chk("t3_err_idle_busy", 32'(t_busy), 32'd0);
    chk("t3_err_no_done", 32'(t_idn), 32'd0);
    inner_start = 1'b1;
    tick();
    inner_start = 1'b0;
    chk("t3_relaunch_err", 32'(t_err), 32'd0);
    chk("t3_relaunch_el", 32'(t_el), 32'd0);
    chk("t3_relaunch_ls", 32'(t_ls), 32'd1);
    chk("t3_relaunch_busy", 32'(t_busy), 32'd1);

    // T5 reset during layer 3
    pulse_reset();
    st = '{1, 11, 21, 31, 41};
    dn = '{10, 20, 30, 40, 50};
    run_img(-1, '0, -1, 33);
    reset = 1'b1;
    tick();
    chk("t5_ls", 32'(a_ls), 32'd0);
    chk("t5_cl", 32'(a_cl), 32'd0);
    chk("t5_busy", 32'(a_busy), 32'd0);
    chk("t5_idn", 32'(a_idn), 32'd0);
    chk("t5_err", 32'(a_err), 32'd0);
    chk("t5_el", 32'(a_el), 32'd0);
    chk("t5_perf", 32'(a_perf), 32'd0);
    reset = 1'b0;
    tick();
    layer_done = 5'b01000;
    tick();
    layer_done = '0;
    tick();
    chk("t5_after_ls", 32'(a_ls), 32'd0);
    chk("t5_after_cl", 32'(a_cl), 32'd0);
    chk("t5_after_busy", 32'(a_busy), 32'd0);
    chk("t5_after_idn", 32'(a_idn), 32'd0);
    chk("t5_after_err", 32'(a_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
